// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail pointer and occupancy controller.
// 2-wide allocate, 3 completion ports, 2-wide in-order retire.
module rob_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       alloc_req,
  output logic [1:0]       alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx_0,
  output logic [IDX_W-1:0] alloc_idx_1,
  output logic             stall,
  input  logic [2:0]       cmp_valid,
  input  logic [IDX_W-1:0] cmp_idx_0,
  input  logic [IDX_W-1:0] cmp_idx_1,
  input  logic [IDX_W-1:0] cmp_idx_2,
  output logic [1:0]       ret_valid,
  output logic [IDX_W-1:0] ret_idx_0,
  output logic [IDX_W-1:0] ret_idx_1,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty,
  input  logic [31:0]      tot_instr_count,
  output logic [31:0]      ret_total,
  output logic             prog_done,
  output logic             err
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] TWO_C   = (IDX_W+1)'(2);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] valid_n;
  logic [DEPTH-1:0] done_n;
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W-1:0] head_p1;
  logic [IDX_W-1:0] tail_p1;
  logic [IDX_W:0]   count_q;
  logic [IDX_W:0]   count_n;
  logic [IDX_W:0]   free;
  logic [31:0]      ret_total_q;
  logic [31:0]      ret_total_n;
  logic             prog_done_q;
  logic             err_q;
  logic [1:0]       gnt;
  logic [1:0]       rv;
  logic [1:0]       nalloc;
  logic [1:0]       nret;
  logic             bad_cmp;
  logic [IDX_W-1:0] cidx [3];

  assign cidx[0] = cmp_idx_0;
  assign cidx[1] = cmp_idx_1;
  assign cidx[2] = cmp_idx_2;

  assign head_p1 = head_q + IDX_W'(1);
  assign tail_p1 = tail_q + IDX_W'(1);

  // Grants use registered occupancy; same-cycle retires free nothing.
  always_comb begin
    free = DEPTH_C - count_q;
    gnt  = '0;
    if (!flush) begin
      gnt[0] = alloc_req[0] && (free >= ONE_C);
      gnt[1] = alloc_req[1] && alloc_req[0]
               && (free >= TWO_C);
    end
  end

  // In-order retire: slot 1 only behind a retiring slot 0.
  always_comb begin
    rv = '0;
    if (!flush && count_q != '0 && done_q[head_q])
      rv[0] = 1'b1;
    if (rv[0] && count_q >= TWO_C && done_q[head_p1])
      rv[1] = 1'b1;
  end

  // Next-state counters and protocol check.
  always_comb begin
    nalloc  = {1'b0, gnt[0]} + {1'b0, gnt[1]};
    nret    = {1'b0, rv[0]} + {1'b0, rv[1]};
    count_n = count_q + (IDX_W+1)'(nalloc)
              - (IDX_W+1)'(nret);
    ret_total_n = ret_total_q + 32'(nret);
    bad_cmp = 1'b0;
    for (int k = 0; k < 3; k++)
      if (cmp_valid[k] && !valid_q[cidx[k]])
        bad_cmp = 1'b1;
  end

  // Per-entry bits: complete, then allocate, then retire.
  always_comb begin
    valid_n = valid_q;
    done_n  = done_q;
    for (int k = 0; k < 3; k++)
      if (cmp_valid[k] && valid_q[cidx[k]])
        done_n[cidx[k]] = 1'b1;
    if (gnt[0]) begin
      valid_n[tail_q] = 1'b1;
      done_n[tail_q]  = 1'b0;
    end
    if (gnt[1]) begin
      valid_n[tail_p1] = 1'b1;
      done_n[tail_p1]  = 1'b0;
    end
    if (rv[0]) begin
      valid_n[head_q] = 1'b0;
      done_n[head_q]  = 1'b0;
    end
    if (rv[1]) begin
      valid_n[head_p1] = 1'b0;
      done_n[head_p1]  = 1'b0;
    end
  end

  // State update; flush empties the ROB but keeps totals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_total_q <= '0;
      prog_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= (alloc_req == 2'b10) || bad_cmp;
      ret_total_q <= ret_total_n;
      if (tot_instr_count != '0
          && ret_total_n >= tot_instr_count)
        prog_done_q <= 1'b1;
      if (flush) begin
        valid_q <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        valid_q <= valid_n;
        done_q  <= done_n;
        head_q  <= head_q + IDX_W'(nret);
        tail_q  <= tail_q + IDX_W'(nalloc);
        count_q <= count_n;
      end
    end
  end

  assign alloc_gnt   = gnt;
  assign alloc_idx_0 = tail_q;
  assign alloc_idx_1 = tail_p1;
  assign stall       = |(alloc_req & ~gnt);
  assign ret_valid   = rv;
  assign ret_idx_0   = head_q;
  assign ret_idx_1   = head_p1;
  assign head        = head_q;
  assign tail        = tail_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign ret_total   = ret_total_q;
  assign prog_done   = prog_done_q;
  assign err         = err_q;

endmodule
